rr_mux16_arbiter: RTL

Round-robin arbiter that shares one 16-input, 32-bit mux path among 16 requesters. It drives the 4-bit select, registers the selected word, and presents it on a valid/ready output port. It sits between requester blocks and a single consumer, such as a shared writeback or bus port, in the processor datapath. Fairness is rotating priority, with an optional lock that grants back-to-back transfers to one requester.

---
 rtl/rr_mux16_arbiter.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/rr_mux16_arbiter.sv
// rr_mux16_arbiter: round-robin 16:1 arbiter with a registered valid/ready output.
// Define ARB_LOCK_EN to let a locked last winner keep the grant back-to-back.
`timescale 1ns/1ps
module rr_mux16_arbiter #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                     clock,
   input  logic                     reset_n,
   input  logic [15:0]              req,
   input  logic [16*DATA_WIDTH-1:0] in_data,
   input  logic [15:0]              lock,
   input  logic                     out_ready,
   output logic [15:0]              grant,
   output logic [3:0]               sel,
   output logic                     out_valid,
   output logic [DATA_WIDTH-1:0]    out_data,
   output logic [3:0]               out_src
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      XFER = 2'd1,
      WAIT = 2'd2
   } state_t;

   state_t                state;
   state_t                state_nx;
   logic [3:0]            last;
   logic [3:0]            last_nx;
   logic [3:0]            win;
   logic [3:0]            idx;
   logic                  found;
   logic                  any_req;
   logic                  hs;
   logic [DATA_WIDTH-1:0] mux_word;
   logic [15:0]           grant_nx;
   logic [3:0]            sel_nx;
   logic                  valid_nx;
   logic [DATA_WIDTH-1:0] data_nx;
   logic [3:0]            src_nx;

   assign any_req = |req;
   assign hs      = out_valid && out_ready;

   always_comb begin
      mux_word = '0;
      for (int i = 0; i < 16; i++) begin
         if (sel == 4'(i)) begin
            mux_word = in_data[DATA_WIDTH*i +: DATA_WIDTH];
         end
      end
   end

   // Scan upward from last+1; the 4-bit add wraps modulo 16.
   always_comb begin
      win   = last;
      idx   = last;
      found = 1'b0;
      for (int k = 1; k <= 16; k++) begin
         idx = last + 4'(k);
         if (!found && req[idx]) begin
            win   = idx;
            found = 1'b1;
         end
      end
`ifdef ARB_LOCK_EN
      if (lock[last] && req[last]) begin
         win = last;
      end
`endif
   end

`ifndef ARB_LOCK_EN
   logic unused_lock;
   assign unused_lock = ^lock;
`endif

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (any_req) state_nx = XFER;
         XFER:    state_nx = WAIT;
         WAIT:    if (hs) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      grant_nx = grant;
      sel_nx   = sel;
      last_nx  = last;
      valid_nx = out_valid;
      data_nx  = out_data;
      src_nx   = out_src;
      unique case (state)
         IDLE: begin
            grant_nx = '0;
            if (any_req) begin
               grant_nx = 16'(1) << win;
               sel_nx   = win;
               last_nx  = win;
            end
         end
         XFER: begin
            data_nx  = mux_word;
            src_nx   = sel;
            valid_nx = 1'b1;
         end
         WAIT: begin
            if (hs) begin
               valid_nx = 1'b0;
               grant_nx = '0;
            end
         end
         default: begin
            grant_nx = '0;
            valid_nx = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         grant     <= '0;
         sel       <= '0;
         last      <= 4'hF;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_src   <= '0;
      end else begin
         grant     <= grant_nx;
         sel       <= sel_nx;
         last      <= last_nx;
         out_valid <= valid_nx;
         out_data  <= data_nx;
         out_src   <= src_nx;
      end
   end

endmodule
